// File: rtl/ex_mdu_pkg.sv
// Shared EX-stage types: MDU operation codes, MDU FSM states and small
// decode helpers used by the multiply/divide unit.
package project_types;

    localparam int MDU_OP_W = 3;

    // MADD/MSUB are always enumerated; whether they are legal is decided by the
    // unit itself (MDU_ACC_EN), so unused encodings stay well defined.
    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MSUB  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } mdu_state_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
// Relies on the invariant rem < divisor, which holds from a zero start.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    // A borrow out of the top bit means the divisor did not fit.
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on magnitudes, sign fix-up in FIN, result in hi_o/lo_o.
// Optional macro MDU_ACC_EN enables MADD/MSUB accumulation into {hi_o,lo_o}.
module ex_mdu
    import project_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] oprd1,
    input  logic [WIDTH-1:0] oprd2,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt;
    // {hi,lo} working register: product for MUL, {remainder, dividend/quotient} for DIV.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sign_q, sign_r;
    mdu_op_t            op_q;

    logic               op_legal, op_signed, accept, div_by_zero, last_iter;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [2*WIDTH-1:0] fin_result;

`ifdef MDU_ACC_EN
    assign op_legal = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) ||
                      (op == MDU_DIVU) || (op == MDU_MADD)  || (op == MDU_MSUB);
`else
    assign op_legal = (op == MDU_MULT) || (op == MDU_MULTU) ||
                      (op == MDU_DIV)  || (op == MDU_DIVU);
`endif

    assign op_signed   = mdu_is_signed(op);
    assign accept      = start && op_legal && !flush && (state == IDLE);
    assign div_by_zero = mdu_is_div(op) && (oprd2 == '0);
    assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
    assign abs1        = (op_signed && oprd1[WIDTH-1]) ? -oprd1 : oprd1;
    assign abs2        = (op_signed && oprd2[WIDTH-1]) ? -oprd2 : oprd2;
    assign stall_req   = busy || (start && op_legal && (state == IDLE));

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set; the carry is kept for the right shift.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc[2*WIDTH-1:WIDTH]),
        .divisor      (opnd),
        .dividend_bit (acc[WIDTH-1]),
        .rem_next     (div_rem),
        .q_bit        (div_qbit)
    );

    assign prod_fix = sign_q ? -acc : acc;
    assign quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // Final result selection: sign-corrected product/quotient, or accumulation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fin_result = prod_fix;
        case (op_q)
            MDU_DIV, MDU_DIVU: fin_result = {rem_fix, quo_fix};
`ifdef MDU_ACC_EN
            MDU_MADD:          fin_result = {hi_o, lo_o} + prod_fix;
            MDU_MSUB:          fin_result = {hi_o, lo_o} - prod_fix;
`endif
            default:           fin_result = prod_fix;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div_by_zero)         state_next = FIN;
                    else if (mdu_is_div(op)) state_next = DIV;
                    else                     state_next = MUL;
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (flush)          state_next = IDLE;
                else if (last_iter) state_next = FIN;
            end
            FIN: begin
                done       = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one iteration per cycle, result write in FIN.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so a reset mid-operation leaves nothing behind.
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            op_q   <= MDU_MULT;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt  <= '0;
                        op_q <= op;
                        if (div_by_zero) begin
                            acc    <= {oprd1, {WIDTH{1'b1}}};
                            opnd   <= '0;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end else begin
                            sign_q <= op_signed && (oprd1[WIDTH-1] ^ oprd2[WIDTH-1]);
                            sign_r <= op_signed && oprd1[WIDTH-1];
                            if (mdu_is_div(op)) begin
                                acc  <= {{WIDTH{1'b0}}, abs1};
                                opnd <= abs2;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, abs2};
                                opnd <= abs1;
                            end
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    acc <= {div_rem, acc[WIDTH-2:0], div_qbit};
                end
                FIN: begin
                    if (!flush) begin
                        hi_o <= fin_result[2*WIDTH-1:WIDTH];
                        lo_o <= fin_result[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
